// File: rtl/knight_scan.sv
// Knight-Rider lamp scanner: one lit lamp bounces or wraps across WIDTH outputs, paced by a div+1 clock-enable prescaler.
// Latency: the qualifying edge updates out/up; tick and end_hit are high for the following cycle. KNIGHT_SCAN_DWELL_EN adds an end-lamp dwell step.
// Backpressure: none; en low freezes prescaler, lamp and direction.
module knight_scan #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input  logic             ck,
    input  logic             res,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             mode,
    output logic [WIDTH-1:0] out,
    output logic             up,
    output logic             tick,
    output logic             end_hit
);

    localparam int PW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [PW-1:0] ZERO = '0;
    localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);

    logic [PW-1:0]    pos;
    logic [PW-1:0]    pos_nxt;
    logic             up_nxt;
    logic             moved;
    logic             landing;
    logic [DIV_W-1:0] cnt;
    logic             step;

    // >= rather than == so lowering div mid-count still fires on the next enabled cycle
    assign step = en && (cnt >= div);

    always_comb begin
        pos_nxt = pos;
        up_nxt  = up;
        moved   = 1'b1;
        if (mode) begin
            if (up) begin
                pos_nxt = (pos == LAST) ? ZERO : pos + 1'b1;
            end else begin
                pos_nxt = (pos == ZERO) ? LAST : pos - 1'b1;
            end
        end else if (up) begin
            if (pos != LAST) begin
                pos_nxt = pos + 1'b1;
            end else begin
                up_nxt = 1'b0;
`ifdef KNIGHT_SCAN_DWELL_EN
                moved  = 1'b0;
`else
                pos_nxt = LAST - 1'b1;
`endif
            end
        end else begin
            if (pos != ZERO) begin
                pos_nxt = pos - 1'b1;
            end else begin
                up_nxt = 1'b1;
`ifdef KNIGHT_SCAN_DWELL_EN
                moved  = 1'b0;
`else
                pos_nxt = ZERO + 1'b1;
`endif
            end
        end
    end

    // A dwell step re-lands on the end lamp but is not an arrival
    assign landing = moved && ((pos_nxt == ZERO) || (pos_nxt == LAST));

    always_ff @(posedge ck or posedge res) begin
        if (res) begin
            pos     <= ZERO;
            out     <= WIDTH'(1);
            up      <= 1'b1;
            cnt     <= '0;
            tick    <= 1'b0;
            end_hit <= 1'b0;
        end else begin
            tick    <= step;
            end_hit <= step && landing;
            if (en) begin
                cnt <= step ? '0 : cnt + 1'b1;
            end
            if (step) begin
                pos <= pos_nxt;
                up  <= up_nxt;
                out <= WIDTH'(1) << pos_nxt;
            end
        end
    end

endmodule

// File: tb/tb_knight_scan.sv
// Bench for knight_scan: WIDTH 8, 2 and 64 instances share stimulus and are checked against a position/direction model.
module tb_knight_scan;

`ifdef KNIGHT_SCAN_DWELL_EN
    localparam bit DWELL = 1'b1;
`else
    localparam bit DWELL = 1'b0;
`endif

    logic        ck;
    logic        res;
    logic        en;
    logic [7:0]  div;
    logic        mode;
    logic [7:0]  out8;
    logic [1:0]  out2;
    logic [63:0] out64;
    logic        up8, up2, up64;
    logic        tick8, tick2, tick64;
    logic        end8, end2, end64;

    knight_scan #(.WIDTH(8), .DIV_W(8)) u8 (
        .ck(ck), .res(res), .en(en), .div(div), .mode(mode),
        .out(out8), .up(up8), .tick(tick8), .end_hit(end8)
    );
    knight_scan #(.WIDTH(2), .DIV_W(8)) u2 (
        .ck(ck), .res(res), .en(en), .div(div), .mode(mode),
        .out(out2), .up(up2), .tick(tick2), .end_hit(end2)
    );
    knight_scan #(.WIDTH(64), .DIV_W(8)) u64 (
        .ck(ck), .res(res), .en(en), .div(div), .mode(mode),
        .out(out64), .up(up64), .tick(tick64), .end_hit(end64)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int nchk = 0;
    int nerr = 0;

    // Reference model: lamp index, direction and prescaler count per instance
    int mw[3] = '{8, 2, 64};
    int mpos[3];
    bit mup[3];
    bit mtick[3];
    bit mend[3];
    int mcnt;

    typedef struct {
        logic       en;
        logic [7:0] div;
        logic       mode;
        logic [7:0] xout;
        logic       xup;
        logic       xtick;
        logic       xend;
    } vec_t;

    vec_t tbl[17];
    int   ntbl;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mcnt = 0;
        for (int i = 0; i < 3; i++) begin
            mpos[i] = 0; mup[i] = 1'b1; mtick[i] = 1'b0; mend[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic e, input int d, input logic m);
        bit st;
        bit mv;
        int w;
        st = e && (mcnt >= d);
        for (int i = 0; i < 3; i++) begin
            w = mw[i];
            mtick[i] = st;
            mend[i]  = 1'b0;
            if (st) begin
                mv = 1'b1;
                if (m) begin
                    mpos[i] = mup[i] ? (mpos[i] + 1) % w : (mpos[i] + w - 1) % w;
                end else if (mup[i]) begin
                    if (mpos[i] < w - 1) mpos[i]++;
                    else begin
                        mup[i] = 1'b0;
                        if (DWELL) mv = 1'b0; else mpos[i] = w - 2;
                    end
                end else begin
                    if (mpos[i] > 0) mpos[i]--;
                    else begin
                        mup[i] = 1'b1;
                        if (DWELL) mv = 1'b0; else mpos[i] = 1;
                    end
                end
                mend[i] = mv && (mpos[i] == 0 || mpos[i] == w - 1);
            end
        end
        if (e) mcnt = st ? 0 : mcnt + 1;
    endtask

    task automatic compare_all();
        chk("out8",  64'(out8),  (64'd1 << mpos[0]));
        chk("up8",   64'(up8),   64'(mup[0]));
        chk("tick8", 64'(tick8), 64'(mtick[0]));
        chk("end8",  64'(end8),  64'(mend[0]));
        chk("out2",  64'(out2),  (64'd1 << mpos[1]));
        chk("up2",   64'(up2),   64'(mup[1]));
        chk("tick2", 64'(tick2), 64'(mtick[1]));
        chk("end2",  64'(end2),  64'(mend[1]));
        chk("out64", out64,      (64'd1 << mpos[2]));
        chk("up64",  64'(up64),  64'(mup[2]));
        chk("tick64",64'(tick64),64'(mtick[2]));
        chk("end64", 64'(end64), 64'(mend[2]));
    endtask

    task automatic cyc();
        logic e;
        int   d;
        logic m;
        e = en; d = int'(div); m = mode;
        @(posedge ck);
        #1;
        model_edge(e, d, m);
        compare_all();
    endtask

    // Reset is raised mid-cycle so its asynchronous effect is observed before any edge
    task automatic do_reset();
        res = 1'b1;
        #1;
        model_reset();
        chk("rst_out8",  64'(out8),  64'h01);
        chk("rst_up8",   64'(up8),   64'd1);
        chk("rst_tick8", 64'(tick8), 64'd0);
        chk("rst_end8",  64'(end8),  64'd0);
        chk("rst_out64", out64,      64'h1);
        @(posedge ck);
        #1;
        res = 1'b0;
    endtask

    logic [7:0] wexp[4];

    initial begin
        res = 1'b1; en = 1'b0; div = 8'd0; mode = 1'b0;
        do_reset();

        // Full bounce sweep from reset, div=0
`ifdef KNIGHT_SCAN_DWELL_EN
        ntbl = 17;
        tbl[0]  = '{1'b1, 8'd0, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 8'd0, 1'b0, 8'h04, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 8'd0, 1'b0, 8'h08, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 8'd0, 1'b0, 8'h10, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 8'd0, 1'b0, 8'h20, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 8'd0, 1'b0, 8'h40, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 8'd0, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 8'd0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 8'd0, 1'b0, 8'h40, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 8'd0, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 8'd0, 1'b0, 8'h10, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 8'd0, 1'b0, 8'h08, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 8'd0, 1'b0, 8'h04, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 8'd0, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 8'd0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b1};
        tbl[15] = '{1'b1, 8'd0, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 8'd0, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0};
`else
        ntbl = 15;
        tbl[0]  = '{1'b1, 8'd0, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 8'd0, 1'b0, 8'h04, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 8'd0, 1'b0, 8'h08, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 8'd0, 1'b0, 8'h10, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 8'd0, 1'b0, 8'h20, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 8'd0, 1'b0, 8'h40, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 8'd0, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 8'd0, 1'b0, 8'h40, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 8'd0, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 8'd0, 1'b0, 8'h10, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 8'd0, 1'b0, 8'h08, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 8'd0, 1'b0, 8'h04, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 8'd0, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 8'd0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b1};
        tbl[14] = '{1'b1, 8'd0, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0};
`endif
        for (int i = 0; i < ntbl; i++) begin
            en = tbl[i].en; div = tbl[i].div; mode = tbl[i].mode;
            cyc();
            chk("tbl_out",  64'(out8),  64'(tbl[i].xout));
            chk("tbl_up",   64'(up8),   64'(tbl[i].xup));
            chk("tbl_tick", 64'(tick8), 64'(tbl[i].xtick));
            chk("tbl_end",  64'(end8),  64'(tbl[i].xend));
        end

        // Async reset mid-sweep at 0x10
        repeat (3) cyc();
        chk("pre_rst_out", 64'(out8), 64'h10);
        do_reset();

        // Prescaler div=3: tick every 4th enabled edge
        div = 8'd3; en = 1'b1; mode = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk("div3_tick", 64'(tick8), 64'((k % 4) == 0));
        end

        // Lowering div below the running count fires on the next enabled edge
        do_reset();
        div = 8'd9; en = 1'b1;
        repeat (5) cyc();
        chk("div9_notick", 64'(out8), 64'h01);
        div = 8'd2;
        cyc();
        chk("div_lower_tick", 64'(tick8), 64'd1);
        chk("div_lower_out",  64'(out8),  64'h02);
        en = 1'b0;
        repeat (10) cyc();
        chk("freeze_out", 64'(out8), 64'h02);
        chk("freeze_up",  64'(up8),  64'd1);
        en = 1'b1;
        repeat (3) cyc();
        chk("resume_out", 64'(out8), 64'h04);

        // Wrap from the MSB lamp
        do_reset();
        div = 8'd0; en = 1'b1; mode = 1'b0;
        repeat (7) cyc();
        chk("wrap_pre", 64'(out8), 64'h80);
        mode = 1'b1;
        cyc();
        chk("wrap_out", 64'(out8), 64'h01);
        chk("wrap_up",  64'(up8),  64'd1);

        // Downward wrap after a bounce reversal
        do_reset();
        mode = 1'b0;
        repeat (DWELL ? 12 : 11) cyc();
        chk("rev_out", 64'(out8), 64'h08);
        chk("rev_up",  64'(up8),  64'd0);
        mode = 1'b1;
        wexp[0] = 8'h04; wexp[1] = 8'h02; wexp[2] = 8'h01; wexp[3] = 8'h80;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("wrap_down", 64'(out8), 64'(wexp[k]));
        end

        // WIDTH=64 reaches bit 63 after 63 steps
        do_reset();
        mode = 1'b0;
        repeat (63) cyc();
        chk("w64_msb", out64, 64'h8000_0000_0000_0000);
        chk("w64_end", 64'(end64), 64'd1);

        // Randomized run against the model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r < 3) do_reset();
            en = ($urandom_range(0, 3) != 0);
            if (r < 20) div = 8'($urandom_range(0, 4));
            if (r >= 20 && r < 26) mode = ~mode;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
